// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with a per-register
// busy scoreboard. Reads are combinational, writes land on the rising edge.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through forwarding).
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic [NUM_WR-1:0]      we,
  input  logic [NUM_WR*AW-1:0]   rd_addr,
  input  logic [NUM_WR*XLEN-1:0] wdata,
  input  logic                   busy_set,
  input  logic [AW-1:0]          busy_addr,
  output logic                   any_busy
);

  localparam bit ZR_EN = (ZERO_REG != 0);

  // Register 0 is hardwired only when the zero-register option is on.
  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZR_EN && (a == {AW{1'b0}});
  endfunction

  logic [XLEN-1:0]  mem_r [NREGS];
  logic [NREGS-1:0] busy_r;

  logic [NREGS-1:0] wr_hit_s;           // register r takes new data this edge
  logic [NREGS-1:0] wr_clr_s;           // some write port targets r (clears busy)
  logic [XLEN-1:0]  wr_val_s [NREGS];   // winning write data for register r
  logic [NREGS-1:0] busy_nxt_s;

  // Decode all write ports per register; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_hit_s[r] = 1'b0;
      wr_clr_s[r] = 1'b0;
      wr_val_s[r] = {XLEN{1'b0}};
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (rd_addr[j*AW +: AW] == AW'(r))) begin
          wr_clr_s[r] = 1'b1;
          if (!is_zero_reg(AW'(r))) begin
            wr_hit_s[r] = 1'b1;
            wr_val_s[r] = wdata[j*XLEN +: XLEN];
          end else begin
            wr_hit_s[r] = 1'b0;
          end
        end else begin
          wr_clr_s[r] = wr_clr_s[r];
        end
      end
    end
  end

  // Busy next state: an issue marks busy and beats a same-cycle writeback clear.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int r = 0; r < NREGS; r++) begin
      if (busy_set && (busy_addr == AW'(r)) && !is_zero_reg(AW'(r))) begin
        busy_nxt_s[r] = 1'b1;
      end else if (wr_clr_s[r]) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Register storage: cleared asynchronously, updated from the write decode otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_r[r] <= {XLEN{1'b0}};
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit_s[r]) begin
          mem_r[r] <= wr_val_s[r];
        end
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Combinational read ports, with optional forwarding of same-cycle writes.
  always_comb begin
    logic [AW-1:0]   ra_s;
    logic [XLEN-1:0] rd_val_s;
    logic            rd_bsy_s;
    rs_data = {(NUM_RD*XLEN){1'b0}};
    rs_busy = {NUM_RD{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      ra_s     = rs_addr[i*AW +: AW];
      rd_val_s = mem_r[ra_s];
      rd_bsy_s = busy_r[ra_s];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (rd_addr[j*AW +: AW] == ra_s)) begin
          rd_val_s = wdata[j*XLEN +: XLEN];
          // A matching write retires the producer unless a new one issues to the same register.
          if (busy_set && (busy_addr == ra_s)) begin
            rd_bsy_s = busy_r[ra_s];
          end else begin
            rd_bsy_s = 1'b0;
          end
        end else begin
          rd_val_s = rd_val_s;
        end
      end
`endif
      if (rst || is_zero_reg(ra_s)) begin
        rs_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rs_busy[i]              = 1'b0;
      end else begin
        rs_data[i*XLEN +: XLEN] = rd_val_s;
        rs_busy[i]              = rd_bsy_s;
      end
    end
  end

  assign any_busy = |busy_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed scenarios plus randomized traffic, checked
// through an expectation queue against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_RD*AW-1:0]   rs_addr = '0;
  logic [NUM_RD*XLEN-1:0] rs_data;
  logic [NUM_RD-1:0]      rs_busy;
  logic [NUM_WR-1:0]      we = '0;
  logic [NUM_WR*AW-1:0]   rd_addr = '0;
  logic [NUM_WR*XLEN-1:0] wdata = '0;
  logic                   busy_set = 1'b0;
  logic [AW-1:0]          busy_addr = '0;
  logic                   any_busy;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .we(we), .rd_addr(rd_addr), .wdata(wdata), .busy_set(busy_set),
    .busy_addr(busy_addr), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_RD*XLEN-1:0] data;
    logic [NUM_RD-1:0]      busy;
    logic                   any;
    logic [63:0]            tag;
  } exp_t;

  exp_t sb_q[$];
  event chk_now;
  int   total = 0;
  int   bad = 0;

  // Reference model: architectural state as plain arrays
  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy [NREGS];

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_mem[r] = '0;
      m_busy[r] = 0;
    end
  endtask

  // What a read of address a should return right now, given current inputs
  function automatic logic [XLEN-1:0] ref_data(input int a);
    logic [XLEN-1:0] v;
    if (rst || a == 0) return '0;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NUM_WR; j++)
      if (we[j] && int'(rd_addr[j*AW +: AW]) == a) v = wdata[j*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic logic ref_busy(input int a);
    logic b;
    if (rst || a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NUM_WR; j++)
      if (we[j] && int'(rd_addr[j*AW +: AW]) == a && !(busy_set && int'(busy_addr) == a)) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic push_exp(input logic [63:0] tag);
    exp_t e;
    int a;
    e.any = 1'b0;
    for (int r = 0; r < NREGS; r++) if (m_busy[r]) e.any = 1'b1;
    for (int i = 0; i < NUM_RD; i++) begin
      a = int'(rs_addr[i*AW +: AW]);
      e.data[i*XLEN +: XLEN] = ref_data(a);
      e.busy[i] = ref_busy(a);
    end
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Apply the architectural effect of the inputs seen at a rising edge
  task automatic model_update();
    int a;
    if (!rst) begin
      for (int j = 0; j < NUM_WR; j++) begin
        a = int'(rd_addr[j*AW +: AW]);
        if (we[j]) begin
          if (a != 0) m_mem[a] = wdata[j*XLEN +: XLEN];
          m_busy[a] = 0;
        end
      end
      if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1;
    end
  endtask

  task automatic cycle(input logic [63:0] tag);
    push_exp(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we = '0;
    busy_set = 1'b0;
  endtask

  // Monitor: pops an expectation whenever one is pending at a sample point
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        total++;
        if (rs_data !== e.data) begin
          bad++;
          $display("FAIL %s rs_data: got %h want %h", e.tag, rs_data, e.data);
        end
        total++;
        if (rs_busy !== e.busy) begin
          bad++;
          $display("FAIL %s rs_busy: got %b want %b", e.tag, rs_busy, e.busy);
        end
        total++;
        if (any_busy !== e.any) begin
          bad++;
          $display("FAIL %s any_busy: got %b want %b", e.tag, any_busy, e.any);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    // 1. reset: outputs zero while held, then every address reads zero
    rs_addr = {5'd2, 5'd1};
    cycle("rst_hold");
    rst = 1'b0;
    for (int a = 0; a < NREGS; a++) begin
      rs_addr = {AW'(NREGS - 1 - a), AW'(a)};
      cycle("rst_scan");
    end
    // 2. write then read back
    we = 2'b01; rd_addr = {5'd0, 5'd1}; wdata = {32'h0, 32'hADCBECAF}; rs_addr = {5'd0, 5'd1};
    cycle("wr_cyc");
    idle();
    cycle("rd_next");
    // 3. register 0 ignores writes and busy_set
    we = 2'b01; rd_addr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFFFFFF};
    busy_set = 1'b1; busy_addr = 5'd0; rs_addr = {5'd0, 5'd0};
    cycle("x0_wr");
    idle();
    cycle("x0_rd");
    // 4. collision: port 1 wins
    we = 2'b11; rd_addr = {5'd2, 5'd2}; wdata = {32'hFDACBDAC, 32'h11111111}; rs_addr = {5'd2, 5'd1};
    cycle("coll_wr");
    idle();
    cycle("coll_rd");
    // 5. scoreboard
    busy_set = 1'b1; busy_addr = 5'd5; rs_addr = {5'd5, 5'd5};
    cycle("bset5");
    idle();
    cycle("busy5");
    we = 2'b01; rd_addr = {5'd0, 5'd5}; wdata = {32'h0, 32'h00000055};
    cycle("wr5");
    idle();
    cycle("clr5");
    busy_set = 1'b1; busy_addr = 5'd7; we = 2'b10; rd_addr = {5'd7, 5'd0};
    wdata = {32'h77777777, 32'h0}; rs_addr = {5'd7, 5'd5};
    cycle("setwr7");
    idle();
    cycle("busy7");
    // 6. asynchronous reset between edges
    we = 2'b01; rd_addr = {5'd0, 5'd3}; wdata = {32'h0, 32'h12345678};
    busy_set = 1'b1; busy_addr = 5'd3;
    cycle("wr3");
    idle();
    rs_addr = {5'd7, 5'd3};
    push_exp("pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_clear();
    push_exp("rst_mid");
    #1;
    -> chk_now;
    @(posedge clk);
    model_update();
    #1;
    we = 2'b11; rd_addr = {5'd7, 5'd3}; wdata = {32'hDEADBEEF, 32'hCAFEF00D};
    busy_set = 1'b1; busy_addr = 5'd3;
    cycle("rst_wr");
    rst = 1'b0;
    idle();
    cycle("post_rst");
    // randomized traffic over a small address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        we[j] = ($urandom_range(3, 0) != 0);
        rd_addr[j*AW +: AW] = AW'($urandom_range(7, 0));
        wdata[j*XLEN +: XLEN] = $urandom;
      end
      for (int i = 0; i < NUM_RD; i++) rs_addr[i*AW +: AW] = AW'($urandom_range(7, 0));
      busy_set = ($urandom_range(1, 0) != 0);
      busy_addr = AW'($urandom_range(7, 0));
      cycle("rand");
    end
    idle();
    cycle("final");
    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
